// File: rtl/m6502_bus_arb.sv
// Shares the 6502 external bus with one DMA master: stalls the core via rdy, grants on a parked read.
// Optional macro M6502_ARB_SYNC_ONLY_EN: only opcode-fetch reads (cpu_sync=1) may be split by a grant.
module m6502_bus_arb #(
    parameter int BURST_MAX = 16,
    parameter int CPU_MIN   = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_datao,
    input  logic        i_cpu_dataenb,
    input  logic        i_cpu_we_n,
    input  logic        i_cpu_sync,
    output logic        o_cpu_rdy,
    input  logic        i_dma_req,
    input  logic [15:0] i_dma_addr,
    input  logic [7:0]  i_dma_datao,
    input  logic        i_dma_we_n,
    output logic        o_dma_ack,
    output logic        o_dma_owner,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_datao,
    output logic        o_mem_dataenb,
    output logic        o_mem_we_n
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RESTORE = 2'd3
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);
    localparam logic [7:0] HOLDOFF_LD = 8'(CPU_MIN);

    state_t     r_state;
    logic       r_cpu_rdy;
    logic [7:0] r_burst_cnt;
    logic [7:0] r_holdoff;

    logic w_sync_ok;
    logic w_park;
    logic w_grant;
    logic w_ack;

`ifdef M6502_ARB_SYNC_ONLY_EN
    assign w_sync_ok = i_cpu_sync;
`else
    // Any parked read qualifies; sync is still folded in so the port is referenced.
    assign w_sync_ok = i_cpu_sync | 1'b1;
`endif

    // rdy cannot halt writes, so only a read seen while rdy is low means the core is parked.
    assign w_park  = i_cpu_we_n & ~r_cpu_rdy & w_sync_ok;
    assign w_grant = (r_state == ST_GRANT);
    assign w_ack   = w_grant & i_dma_req;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cpu_rdy   <= 1'b1;
            r_burst_cnt <= 8'd0;
            r_holdoff   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cpu_rdy <= 1'b1;
                    if (r_holdoff != 8'd0) begin
                        r_holdoff <= r_holdoff - 8'd1;
                    end else if (i_dma_req) begin
                        r_state   <= ST_STALL;
                        r_cpu_rdy <= 1'b0;
                    end
                end
                ST_STALL: begin
                    r_cpu_rdy <= 1'b0;
                    if (!i_dma_req) begin
                        r_state <= ST_RESTORE;
                    end else if (w_park) begin
                        r_state     <= ST_GRANT;
                        r_burst_cnt <= 8'd0;
                    end
                end
                ST_GRANT: begin
                    r_cpu_rdy <= 1'b0;
                    if (!i_dma_req) begin
                        r_state <= ST_RESTORE;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                        if (r_burst_cnt == BURST_LAST) begin
                            r_state <= ST_RESTORE;
                        end
                    end
                end
                ST_RESTORE: begin
                    // Core address is back on the bus this cycle; release rdy once memory re-presents data.
                    r_state   <= ST_IDLE;
                    r_cpu_rdy <= 1'b1;
                    r_holdoff <= HOLDOFF_LD;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cpu_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign o_cpu_rdy   = r_cpu_rdy;
    assign o_dma_owner = w_grant;
    assign o_dma_ack   = w_ack;

    always_comb begin
        o_mem_addr    = i_cpu_addr;
        o_mem_datao   = i_cpu_datao;
        o_mem_dataenb = i_cpu_dataenb;
        o_mem_we_n    = i_cpu_we_n;
        if (w_grant) begin
            o_mem_addr    = i_dma_addr;
            o_mem_datao   = i_dma_datao;
            o_mem_dataenb = ~i_dma_we_n;
            o_mem_we_n    = i_dma_we_n;
        end
    end

endmodule

// File: tb/tb_m6502_bus_arb.sv
// Directed bench for m6502_bus_arb (BURST_MAX=4, CPU_MIN=2); checks control outputs and bus mux every cycle.
module tb_m6502_bus_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_datao;
    logic        cpu_dataenb;
    logic        cpu_we_n;
    logic        cpu_sync;
    logic        cpu_rdy;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_datao;
    logic        dma_we_n;
    logic        dma_ack;
    logic        dma_owner;
    logic [15:0] mem_addr;
    logic [7:0]  mem_datao;
    logic        mem_dataenb;
    logic        mem_we_n;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    m6502_bus_arb #(.BURST_MAX(4), .CPU_MIN(2)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cpu_addr(cpu_addr), .i_cpu_datao(cpu_datao), .i_cpu_dataenb(cpu_dataenb),
        .i_cpu_we_n(cpu_we_n), .i_cpu_sync(cpu_sync), .o_cpu_rdy(cpu_rdy),
        .i_dma_req(dma_req), .i_dma_addr(dma_addr), .i_dma_datao(dma_datao),
        .i_dma_we_n(dma_we_n), .o_dma_ack(dma_ack), .o_dma_owner(dma_owner),
        .o_mem_addr(mem_addr), .o_mem_datao(mem_datao), .o_mem_dataenb(mem_dataenb),
        .o_mem_we_n(mem_we_n)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus expectation follows the expected owner, never the DUT's own owner output.
    task automatic check_bus(input string tag, input logic exp_owner);
        logic [25:0] exp_bus;
        if (exp_owner) exp_bus = {dma_addr, dma_datao, ~dma_we_n, dma_we_n};
        else           exp_bus = {cpu_addr, cpu_datao, cpu_dataenb, cpu_we_n};
        check_val({tag, " bus"}, {6'd0, mem_addr, mem_datao, mem_dataenb, mem_we_n}, {6'd0, exp_bus});
    endtask

    // One clock cycle: drive at posedge+1, check at negedge; exp_ctl = {cpu_rdy, dma_owner, dma_ack}.
    task automatic cyc(input string tag, input logic req, input logic we_n, input logic sync,
                       input logic [2:0] exp_ctl);
        dma_req     = req;
        cpu_we_n    = we_n;
        cpu_dataenb = ~we_n;
        cpu_sync    = sync;
        cpu_addr    = cpu_addr + 16'h0101;
        cpu_datao   = cpu_datao + 8'h11;
        dma_addr    = dma_addr + 16'h0003;
        dma_datao   = dma_datao + 8'h05;
        dma_we_n    = ~dma_we_n;
        @(negedge clk);
        check_val({tag, " ctl"}, {29'd0, cpu_rdy, dma_owner, dma_ack}, {29'd0, exp_ctl});
        check_bus(tag, exp_ctl[1]);
        @(posedge clk);
        #1;
    endtask

    task automatic idle3(input string tag);
        for (int i = 0; i < 3; i++) cyc(tag, 1'b0, 1'b1, 1'b0, 3'b100);
    endtask

    initial begin
        reset = 1'b1;
        cpu_addr = 16'h1200; cpu_datao = 8'h40; cpu_dataenb = 1'b0; cpu_we_n = 1'b1;
        cpu_sync = 1'b0; dma_req = 1'b0; dma_addr = 16'hA000; dma_datao = 8'h80; dma_we_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset ctl", {29'd0, cpu_rdy, dma_owner, dma_ack}, 32'd4);
        check_bus("reset", 1'b0);
        reset = 1'b0;

        // Three transfers then drop: grant cycle with req low, then RESTORE, then IDLE.
        cyc("t1 c0", 1, 1, 0, 3'b100);
        cyc("t1 c1", 1, 1, 0, 3'b000);
        cyc("t1 c2", 1, 1, 0, 3'b011);
        cyc("t1 c3", 1, 1, 0, 3'b011);
        cyc("t1 c4", 1, 1, 0, 3'b011);
        cyc("t1 c5", 0, 1, 0, 3'b010);
        cyc("t1 c6", 0, 1, 0, 3'b000);
        idle3("t1 idle");

        // Request during a 3-write push: core writes pass through while stalled.
        cyc("t2 w0", 1, 0, 0, 3'b100);
        cyc("t2 w1", 1, 0, 0, 3'b000);
        cyc("t2 w2", 1, 0, 0, 3'b000);
        cyc("t2 rd", 1, 1, 0, 3'b000);
        cyc("t2 g0", 1, 1, 0, 3'b011);
        cyc("t2 g1", 0, 1, 0, 3'b010);
        cyc("t2 rs", 0, 1, 0, 3'b000);
        idle3("t2 idle");

        // Held request: 4-ack bursts separated by RESTORE and holdoff IDLE cycles (2 decrement + 1 accept).
        for (int b = 0; b < 2; b++) begin
            if (b == 0) cyc("t3 idle", 1, 1, 0, 3'b100);
            cyc("t3 stall", 1, 1, 0, 3'b000);
            for (int k = 0; k < 4; k++) cyc("t3 ack", 1, 1, 0, 3'b011);
            cyc("t3 restore", 1, 1, 0, 3'b000);
            if (b == 0) begin
                cyc("t3 hold2", 1, 1, 0, 3'b100);
                cyc("t3 hold1", 1, 1, 0, 3'b100);
                cyc("t3 accept", 1, 1, 0, 3'b100);
            end
        end
        idle3("t3 idle");

        // Asynchronous reset in the middle of a grant.
        cyc("t4 c0", 1, 1, 0, 3'b100);
        cyc("t4 c1", 1, 1, 0, 3'b000);
        cyc("t4 c2", 1, 1, 0, 3'b011);
        #2 reset = 1'b1;
        #1;
        check_val("t4 async ctl", {29'd0, cpu_rdy, dma_owner, dma_ack}, 32'd4);
        check_bus("t4 async", 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc("t4 idle", 1, 1, 0, 3'b100);
        cyc("t4 stall", 0, 0, 0, 3'b000);
        cyc("t4 restore", 0, 0, 0, 3'b000);
        idle3("t4 post");

        // One-cycle pulse before the core parks: rdy low for exactly two cycles, no ack.
        cyc("t5 c0", 1, 0, 0, 3'b100);
        cyc("t5 stall", 0, 0, 0, 3'b000);
        cyc("t5 restore", 0, 0, 0, 3'b000);
        idle3("t5 idle");

`ifdef M6502_ARB_SYNC_ONLY_EN
        // Operand reads do not qualify; the sync read does, first ack the cycle after.
        cyc("t6 c0", 1, 1, 0, 3'b100);
        cyc("t6 op1", 1, 1, 0, 3'b000);
        cyc("t6 op2", 1, 1, 0, 3'b000);
        cyc("t6 sync", 1, 1, 1, 3'b000);
        cyc("t6 ack", 1, 1, 0, 3'b011);
        cyc("t6 drop", 0, 1, 0, 3'b010);
        cyc("t6 restore", 0, 1, 0, 3'b000);
        idle3("t6 idle");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
